// File: rtl/disp_scan_mux_pkg.sv
// Shared constants and width helpers for the display scan blocks.
package disp_scan_mux_pkg;

   localparam int DISP_MAX_DIGITS      = 8;
   localparam int DISP_CLK_DIV_100MHZ  = 100000;

   localparam logic [DISP_MAX_DIGITS-1:0] DISP_AN_OFF = '1;

   function automatic int disp_idx_w(input int n_digits);
      return (n_digits <= 2) ? 1 : $clog2(n_digits);
   endfunction

   function automatic int disp_cnt_w(input int clk_div);
      return (clk_div <= 2) ? 1 : $clog2(clk_div);
   endfunction

endpackage

// File: rtl/disp_prescaler.sv
// Slot-rate prescaler: counts 0..CLK_DIV-1 and flags the first and last cycle of each slot.
module disp_prescaler
   import disp_scan_mux_pkg::*;
#(
   parameter int CLK_DIV = DISP_CLK_DIV_100MHZ
) (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_slot_end,
   output logic o_slot_start
);

   localparam int CW = disp_cnt_w(CLK_DIV);

   logic [CW-1:0] r_cnt;

   assign o_slot_end   = (r_cnt == CW'(CLK_DIV - 1));
   assign o_slot_start = (r_cnt == '0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (o_slot_end) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/disp_scan_mux.sv
// Multiplexed display scanner with frame-boundary double buffering; outputs registered (1 clk).
// Optional leading-zero blanking is enabled by defining DISP_LEADING_ZERO_BLANK_EN.
module disp_scan_mux
   import disp_scan_mux_pkg::*;
#(
   parameter int CLK_DIV  = DISP_CLK_DIV_100MHZ,
   parameter int N_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*N_DIGITS-1:0]   data_in,
   input  logic [N_DIGITS-1:0]     dp_in,
   input  logic                    load,
   output logic [3:0]              bin,
   output logic [N_DIGITS-1:0]     an,
   output logic                    dp,
   output logic                    frame_tick,
   output logic                    pend
);

   localparam int IW = disp_idx_w(N_DIGITS);
   localparam int DW = 4 * N_DIGITS;
   localparam logic [N_DIGITS-1:0] AN_OFF = DISP_AN_OFF[N_DIGITS-1:0];

   logic                w_slot_end;
   logic                w_slot_start;
   logic                w_frame_end;

   logic [IW-1:0]       r_idx;
   logic [DW-1:0]       r_active;
   logic [N_DIGITS-1:0] r_active_dp;
   logic [DW-1:0]       r_pending;
   logic [N_DIGITS-1:0] r_pending_dp;
   logic                r_pend;

   logic [3:0]          r_bin;
   logic [N_DIGITS-1:0] r_an;
   logic                r_dp;
   logic                r_frame_tick;

   logic [3:0]          w_bin;
   logic [N_DIGITS-1:0] w_an;
   logic                w_dp_lit;
   logic [N_DIGITS-1:0] w_blank_vec;

   disp_prescaler #(
      .CLK_DIV      (CLK_DIV)
   ) u_prescaler (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .o_slot_end   (w_slot_end),
      .o_slot_start (w_slot_start)
   );

   assign w_frame_end = w_slot_end && (r_idx == IW'(N_DIGITS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx <= '0;
      end else if (w_slot_end) begin
         r_idx <= w_frame_end ? '0 : r_idx + IW'(1);
      end
   end

   // A load coinciding with the frame boundary goes straight to active so it is not delayed a frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_active     <= '0;
         r_active_dp  <= '0;
         r_pending    <= '0;
         r_pending_dp <= '0;
         r_pend       <= 1'b0;
      end else if (load && w_frame_end) begin
         r_active     <= data_in;
         r_active_dp  <= dp_in;
         r_pend       <= 1'b0;
      end else begin
         if (w_frame_end && r_pend) begin
            r_active    <= r_pending;
            r_active_dp <= r_pending_dp;
            r_pend      <= 1'b0;
         end
         if (load) begin
            r_pending    <= data_in;
            r_pending_dp <= dp_in;
            r_pend       <= 1'b1;
         end
      end
   end

`ifdef DISP_LEADING_ZERO_BLANK_EN
   // Walk from the most-significant digit down; digit 0 is never blanked.
   always_comb begin
      logic v_zero;
      w_blank_vec = '0;
      v_zero      = 1'b1;
      for (int i = N_DIGITS - 1; i >= 1; i--) begin
         v_zero         = v_zero && (r_active[4*i +: 4] == 4'd0);
         w_blank_vec[i] = v_zero;
      end
   end
`else
   assign w_blank_vec = '0;
`endif

   always_comb begin
      w_bin    = 4'd0;
      w_dp_lit = 1'b0;
      w_an     = AN_OFF;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (r_idx == IW'(i)) begin
            w_bin    = r_active[4*i +: 4];
            w_dp_lit = r_active_dp[i] && !w_blank_vec[i];
            if (!w_slot_start && !w_blank_vec[i]) begin
               w_an[i] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bin        <= 4'd0;
         r_an         <= AN_OFF;
         r_dp         <= 1'b1;
         r_frame_tick <= 1'b0;
      end else begin
         r_bin        <= w_bin;
         r_an         <= w_an;
         r_dp         <= ~w_dp_lit;
         r_frame_tick <= w_frame_end;
      end
   end

   assign bin        = r_bin;
   assign an         = r_an;
   assign dp         = r_dp;
   assign frame_tick = r_frame_tick;
   assign pend       = r_pend;

endmodule
